// File: rtl/serial_sub_param.sv
// Multi-cycle subtractor: computes a - b - borrowIn, DIGIT bits per clock, with
// the borrow registered between steps and a start/busy/done handshake.
module serial_sub_param #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrowIn,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] difference,
   output logic             borrowOut,
   output logic             overflow,
   output logic             zero
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   generate
      if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("serial_sub_param: need WIDTH >= 2, 1 <= DIGIT <= WIDTH, WIDTH %% DIGIT == 0");
      end
   endgenerate

   // Ripple of DIGIT full-subtractor cells; returns {borrow into top cell, borrow out, diff bits}.
   function automatic logic [DIGIT+1:0] ripple(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             bin);
      logic [DIGIT-1:0] d;
      logic             bi;
      logic             btop;
      d    = '0;
      bi   = bin;
      btop = bin;
      for (int i = 0; i < DIGIT; i++) begin
         btop = bi;
         d[i] = x[i] ^ y[i] ^ bi;
         bi   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bi);
      end
      return {btop, bi, d};
   endfunction

   logic [1:0]       state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] res;
   logic             br;
   logic [CW-1:0]    cnt;

   logic [DIGIT+1:0] rip;
   logic [DIGIT-1:0] dig;
   logic             bout;
   logic             btop;
   logic [WIDTH-1:0] res_next;
   logic             last;

   assign rip  = ripple(sa[DIGIT-1:0], sb[DIGIT-1:0], br);
   assign dig  = rip[DIGIT-1:0];
   assign bout = rip[DIGIT];
   assign btop = rip[DIGIT+1];
   assign last = (cnt == LAST);

   // New digits enter from the MSB side so the LSB digit ends up at the bottom.
   generate
      if (DIGIT == WIDTH) begin : g_single
         assign res_next = dig;
      end else begin : g_multi
         assign res_next = {dig, res[WIDTH-1:DIGIT]};
      end
   endgenerate

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state      <= IDLE;
         sa         <= '0;
         sb         <= '0;
         res        <= '0;
         br         <= 1'b0;
         cnt        <= '0;
         difference <= '0;
         borrowOut  <= 1'b0;
         overflow   <= 1'b0;
         zero       <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  br    <= borrowIn;
                  res   <= '0;
                  cnt   <= '0;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               sa  <= sa >> DIGIT;
               sb  <= sb >> DIGIT;
               br  <= bout;
               res <= res_next;
               cnt <= cnt + CW'(1);
               if (last) begin
                  difference <= res_next;
                  borrowOut  <= bout;
                  overflow   <= btop ^ bout;
                  zero       <= (res_next == '0);
                  state      <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_sub_param.sv
// Bench for serial_sub_param: three instances (DIGIT = 2, 1, 8) at WIDTH 8,
// each checked against an integer-arithmetic reference model.
module tb_serial_sub_param;

   logic       clk;
   logic       resetN;
   logic       start_v [3];
   logic [7:0] a_v     [3];
   logic [7:0] b_v     [3];
   logic       bin_v   [3];
   logic       busy_v  [3];
   logic       done_v  [3];
   logic [7:0] diff_v  [3];
   logic       bout_v  [3];
   logic       ovf_v   [3];
   logic       zero_v  [3];

   int         lat  [3] = '{4, 8, 1};
   logic [7:0] prev [3];
   int         tests = 0;
   int         fails = 0;

   serial_sub_param #(.WIDTH(8), .DIGIT(2)) u_d2 (
      .clk(clk), .resetN(resetN), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
      .borrowIn(bin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .difference(diff_v[0]),
      .borrowOut(bout_v[0]), .overflow(ovf_v[0]), .zero(zero_v[0]));

   serial_sub_param #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .resetN(resetN), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
      .borrowIn(bin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .difference(diff_v[1]),
      .borrowOut(bout_v[1]), .overflow(ovf_v[1]), .zero(zero_v[1]));

   serial_sub_param #(.WIDTH(8), .DIGIT(8)) u_d8 (
      .clk(clk), .resetN(resetN), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
      .borrowIn(bin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .difference(diff_v[2]),
      .borrowOut(bout_v[2]), .overflow(ovf_v[2]), .zero(zero_v[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic issue(input int u, input logic [7:0] x, input logic [7:0] y, input logic bi);
      a_v[u]     = x;
      b_v[u]     = y;
      bin_v[u]   = bi;
      start_v[u] = 1'b1;
   endtask

   task automatic check_all_zero(input int u, input string when);
      check($sformatf("u%0d %s busy", u, when), 32'(busy_v[u]), 0);
      check($sformatf("u%0d %s done", u, when), 32'(done_v[u]), 0);
      check($sformatf("u%0d %s diff", u, when), 32'(diff_v[u]), 0);
      check($sformatf("u%0d %s bout", u, when), 32'(bout_v[u]), 0);
      check($sformatf("u%0d %s ovf",  u, when), 32'(ovf_v[u]),  0);
      check($sformatf("u%0d %s zero", u, when), 32'(zero_v[u]), 0);
   endtask

   // Called at a negedge right after issue(); follows the operation to completion.
   task automatic collect(input int u, input logic [7:0] x, input logic [7:0] y, input logic bi,
                          input bit inject, input bit chain,
                          input logic [7:0] cx, input logic [7:0] cy, input logic cbi);
      int         d, s, l;
      logic [7:0] ed;
      logic       eb, eo, ez;
      l  = lat[u];
      d  = int'(x) - int'(y) - int'(bi);
      ed = 8'(d);
      eb = (d < 0);
      s  = int'($signed(x)) - int'($signed(y)) - int'(bi);
      eo = (s < -128) || (s > 127);
      ez = (ed == 8'h00);
      @(posedge clk);
      @(negedge clk);
      start_v[u] = 1'b0;
      for (int n = 1; n <= l + 1; n++) begin
         @(negedge clk);
         start_v[u] = 1'b0;
         if (n < l) begin
            check($sformatf("u%0d run busy n%0d", u, n), 32'(busy_v[u]), 1);
            check($sformatf("u%0d run done n%0d", u, n), 32'(done_v[u]), 0);
            check($sformatf("u%0d run hold n%0d", u, n), 32'(diff_v[u]), 32'(prev[u]));
            if (inject && n == 2) begin
               a_v[u]     = 8'($urandom);
               b_v[u]     = 8'($urandom);
               bin_v[u]   = 1'($urandom);
               start_v[u] = 1'b1;
            end
         end else if (n == l) begin
            check($sformatf("u%0d done %h-%h-%0d", u, x, y, bi), 32'(done_v[u]), 1);
            check($sformatf("u%0d busy@done", u), 32'(busy_v[u]), 0);
            check($sformatf("u%0d diff %h-%h-%0d", u, x, y, bi), 32'(diff_v[u]), 32'(ed));
            check($sformatf("u%0d bout %h-%h-%0d", u, x, y, bi), 32'(bout_v[u]), 32'(eb));
            check($sformatf("u%0d ovf %h-%h-%0d",  u, x, y, bi), 32'(ovf_v[u]),  32'(eo));
            check($sformatf("u%0d zero %h-%h-%0d", u, x, y, bi), 32'(zero_v[u]), 32'(ez));
            prev[u] = ed;
            if (chain) begin
               issue(u, cx, cy, cbi);
               return;
            end
         end else begin
            check($sformatf("u%0d idle done", u), 32'(done_v[u]), 0);
            check($sformatf("u%0d idle busy", u), 32'(busy_v[u]), 0);
            check($sformatf("u%0d idle hold", u), 32'(diff_v[u]), 32'(ed));
         end
      end
   endtask

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic       bi;
   } op_t;

   op_t dir [5] = '{'{8'h35, 8'h12, 1'b0}, '{8'h12, 8'h35, 1'b0}, '{8'h80, 8'h01, 1'b0},
                    '{8'h00, 8'h00, 1'b1}, '{8'h5A, 8'h5A, 1'b0}};

   initial begin
      logic [7:0] rx, ry;
      logic       rb;
      resetN = 1'b0;
      for (int u = 0; u < 3; u++) begin
         start_v[u] = 1'b0;
         a_v[u]     = '0;
         b_v[u]     = '0;
         bin_v[u]   = 1'b0;
         prev[u]    = '0;
      end
      repeat (2) @(negedge clk);
      for (int u = 0; u < 3; u++) check_all_zero(u, "reset");
      resetN = 1'b1;
      @(negedge clk);

      for (int u = 0; u < 3; u++) begin
         for (int i = 0; i < 5; i++) begin
            issue(u, dir[i].x, dir[i].y, dir[i].bi);
            collect(u, dir[i].x, dir[i].y, dir[i].bi, (i == 0) && (lat[u] >= 3), 1'b0, 8'h0, 8'h0, 1'b0);
         end
         // Back-to-back: second op presented during the DONE cycle of the first.
         issue(u, 8'h80, 8'h01, 1'b0);
         collect(u, 8'h80, 8'h01, 1'b0, 1'b0, 1'b1, 8'h7F, 8'hFF, 1'b0);
         collect(u, 8'h7F, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0);
         for (int i = 0; i < 12; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rb = 1'($urandom);
            if (i % 4 == 0) ry = rx;
            issue(u, rx, ry, rb);
            collect(u, rx, ry, rb, (lat[u] >= 3) && 1'($urandom), 1'b0, 8'h0, 8'h0, 1'b0);
         end
      end

      // Reset in the middle of an operation on the multi-cycle instances.
      @(negedge clk);
      issue(0, 8'h35, 8'h12, 1'b0);
      issue(1, 8'h35, 8'h12, 1'b0);
      @(negedge clk);
      start_v[0] = 1'b0;
      start_v[1] = 1'b0;
      repeat (2) @(negedge clk);
      check("u0 busy before reset", 32'(busy_v[0]), 1);
      check("u1 busy before reset", 32'(busy_v[1]), 1);
      #2 resetN = 1'b0;
      #1;
      for (int u = 0; u < 3; u++) check_all_zero(u, "async reset");
      @(negedge clk);
      resetN = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         check($sformatf("u0 no done after reset n%0d", n), 32'(done_v[0] | busy_v[0]), 0);
         check($sformatf("u1 no done after reset n%0d", n), 32'(done_v[1] | busy_v[1]), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
